// File: rtl/prt_frame_writer_if.sv
// RX byte stream plus PRT write-port signals between the MAC/PRT environment and the frame writer.
// master is the environment side; slave is the frame writer.
interface prt_frame_writer_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned SLOT_W = 1
);
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_last;
  logic              s_error;
  logic              prt_slot_free;
  logic [SLOT_W-1:0] prt_slot;
  logic              prt_start;
  logic              prt_write;
  logic [DATA_W-1:0] prt_wdata;
  logic              prt_finish;
  logic              prt_invalidate;
  logic [SLOT_W-1:0] prt_inv_slot;

  modport master (
    output s_valid, s_data, s_last, s_error, prt_slot_free, prt_slot,
    input  prt_start, prt_write, prt_wdata, prt_finish, prt_invalidate, prt_inv_slot
  );

  modport slave (
    input  s_valid, s_data, s_last, s_error, prt_slot_free, prt_slot,
    output prt_start, prt_write, prt_wdata, prt_finish, prt_invalidate, prt_inv_slot
  );
endinterface

// File: rtl/prt_frame_writer.sv
// Claims a PRT slot per RX frame, writes its bytes, then finishes or invalidates the entry.
// Captures dst MAC / ethertype and reports committed frames with a frame_done descriptor.
module prt_frame_writer #(
  parameter int unsigned DATA_W          = 8,
  parameter int unsigned SLOT_W          = 1,
  parameter int unsigned MIN_FRAME_BYTES = 60,
  parameter int unsigned MAX_FRAME_BYTES = 1518,
  parameter int unsigned CNT_W           = 16
) (
  input  logic              clk,
  input  logic              reset,
  prt_frame_writer_if.slave bus,
  output logic              frame_done,
  output logic [SLOT_W-1:0] done_slot,
  output logic [CNT_W-1:0]  done_len,
  output logic [47:0]       hdr_dst_mac,
  output logic [15:0]       hdr_ethertype,
  output logic [CNT_W-1:0]  drop_count,
  output logic [CNT_W-1:0]  err_count,
  output logic              ifg_violation
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StRecv   = 3'd1;
  localparam logic [2:0] StFinish = 3'd2;
  localparam logic [2:0] StAbort  = 3'd3;
  localparam logic [2:0] StDrop   = 3'd4;

  localparam logic [CNT_W-1:0] MinLen = CNT_W'(MIN_FRAME_BYTES);
  localparam logic [CNT_W-1:0] MaxLen = CNT_W'(MAX_FRAME_BYTES);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic [SLOT_W-1:0] cur_slot_q, cur_slot_d;
  logic              start_q, start_d, write_q, write_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              finish_q, finish_d, inv_q, inv_d;
  logic [SLOT_W-1:0] inv_slot_q, inv_slot_d;
  logic              done_q, done_d;
  logic [SLOT_W-1:0] done_slot_q, done_slot_d;
  logic [CNT_W-1:0]  done_len_q, done_len_d;
  logic [47:0]       mac_q, mac_d;
  logic [15:0]       eth_q, eth_d;
  logic [CNT_W-1:0]  drop_q, drop_d, err_q, err_d;
  logic              ifg_q, ifg_d;

  logic              accept;
  logic [CNT_W-1:0]  beat_idx;

  // A beat is written when it opens a frame with a free slot, or extends one still under MAX.
  always_comb begin
    beat_idx = (state_q == StIdle) ? '0 : byte_cnt_q;
    accept   = bus.s_valid && (((state_q == StIdle) && bus.prt_slot_free) ||
                               ((state_q == StRecv) && (byte_cnt_q != MaxLen)));
  end

  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    cur_slot_d  = cur_slot_q;
    start_d     = 1'b0;
    write_d     = 1'b0;
    wdata_d     = wdata_q;
    finish_d    = 1'b0;
    inv_d       = 1'b0;
    inv_slot_d  = inv_slot_q;
    done_d      = 1'b0;
    done_slot_d = done_slot_q;
    done_len_d  = done_len_q;
    mac_d       = mac_q;
    eth_d       = eth_q;
    drop_d      = drop_q;
    err_d       = err_q;
    ifg_d       = ifg_q;

    if (accept) begin
      write_d    = 1'b1;
      wdata_d    = bus.s_data;
      byte_cnt_d = beat_idx + 1'b1;
      if (beat_idx < CNT_W'(6)) mac_d = {mac_q[47-DATA_W:0], bus.s_data};
      if ((beat_idx == CNT_W'(12)) || (beat_idx == CNT_W'(13))) begin
        eth_d = {eth_q[15-DATA_W:0], bus.s_data};
      end
      if (state_q == StIdle) begin
        start_d    = 1'b1;
        cur_slot_d = bus.prt_slot;
        state_d    = StRecv;
      end
      if (bus.s_last) begin
        state_d = (!bus.s_error && (byte_cnt_d >= MinLen)) ? StFinish : StAbort;
      end
    end

    case (state_q)
      StIdle: begin
        if (bus.s_valid && !bus.prt_slot_free) begin
          drop_d = sat_inc(drop_q);
          if (!bus.s_last) state_d = StDrop;
        end
      end
      StRecv: begin
        if (bus.s_valid && (byte_cnt_q == MaxLen)) begin
          inv_d      = 1'b1;
          inv_slot_d = cur_slot_q;
          drop_d     = sat_inc(drop_q);
          state_d    = bus.s_last ? StIdle : StDrop;
        end
      end
      StFinish: begin
        finish_d    = 1'b1;
        done_d      = 1'b1;
        done_slot_d = cur_slot_q;
        done_len_d  = byte_cnt_q;
        if (bus.s_valid) ifg_d = 1'b1;
        state_d     = StIdle;
      end
      StAbort: begin
        inv_d      = 1'b1;
        inv_slot_d = cur_slot_q;
        err_d      = sat_inc(err_q);
        if (bus.s_valid) ifg_d = 1'b1;
        state_d    = StIdle;
      end
      StDrop: begin
        if (bus.s_valid && bus.s_last) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      byte_cnt_q  <= '0;
      cur_slot_q  <= '0;
      start_q     <= 1'b0;
      write_q     <= 1'b0;
      wdata_q     <= '0;
      finish_q    <= 1'b0;
      inv_q       <= 1'b0;
      inv_slot_q  <= '0;
      done_q      <= 1'b0;
      done_slot_q <= '0;
      done_len_q  <= '0;
      mac_q       <= '0;
      eth_q       <= '0;
      drop_q      <= '0;
      err_q       <= '0;
      ifg_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      cur_slot_q  <= cur_slot_d;
      start_q     <= start_d;
      write_q     <= write_d;
      wdata_q     <= wdata_d;
      finish_q    <= finish_d;
      inv_q       <= inv_d;
      inv_slot_q  <= inv_slot_d;
      done_q      <= done_d;
      done_slot_q <= done_slot_d;
      done_len_q  <= done_len_d;
      mac_q       <= mac_d;
      eth_q       <= eth_d;
      drop_q      <= drop_d;
      err_q       <= err_d;
      ifg_q       <= ifg_d;
    end
  end

  assign bus.prt_start      = start_q;
  assign bus.prt_write      = write_q;
  assign bus.prt_wdata      = wdata_q;
  assign bus.prt_finish     = finish_q;
  assign bus.prt_invalidate = inv_q;
  assign bus.prt_inv_slot   = inv_slot_q;
  assign frame_done         = done_q;
  assign done_slot          = done_slot_q;
  assign done_len           = done_len_q;
  assign hdr_dst_mac        = mac_q;
  assign hdr_ethertype      = eth_q;
  assign drop_count         = drop_q;
  assign err_count          = err_q;
  assign ifg_violation      = ifg_q;

endmodule
